// File: rtl/instruction_loader.sv
// Assembles little-endian UART bytes into instruction words and writes them to
// instruction memory, clearing memory at session start and stopping on HALT_INSTR.
module instruction_loader #(
  parameter int                         WORD_WIDTH_BITS = 32,
  parameter int                         BYTE_SIZE       = 8,
  parameter logic [WORD_WIDTH_BITS-1:0] HALT_INSTR      = 32'hFFFFFFFF,
  parameter int                         COUNT_WIDTH     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [BYTE_SIZE-1:0]       i_rx_data,
  input  logic                       i_rx_valid,
  input  logic                       i_mem_full,
  output logic [WORD_WIDTH_BITS-1:0] o_instruction,
  output logic                       o_inst_write,
  output logic                       o_clear,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic [COUNT_WIDTH-1:0]     o_word_count
);

  localparam int NB = WORD_WIDTH_BITS / BYTE_SIZE;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, RECEIVE, WRITE, DONE, ERROR
  } state_e;

  state_e                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [WORD_WIDTH_BITS-1:0] asm_q, asm_d;
  logic [COUNT_WIDTH-1:0]     cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    cnt_d        = cnt_q;
    o_clear      = 1'b0;
    o_inst_write = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (i_start) state_d = CLEAR;
      end
      CLEAR: begin
        o_clear = 1'b1;
        idx_d   = '0;
        asm_d   = '0;
        cnt_d   = '0;
        state_d = RECEIVE;
      end
      RECEIVE: begin
        if (i_start) begin
          state_d = CLEAR;
        end else if (i_rx_valid) begin
          asm_d[BYTE_SIZE*int'(idx_q) +: BYTE_SIZE] = i_rx_data;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WRITE: begin
        // An abort takes priority over the write so the half-session word never lands.
        if (i_start) begin
          state_d = CLEAR;
        end else if (i_mem_full) begin
          state_d = ERROR;
        end else begin
          o_inst_write = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          state_d = (asm_q == HALT_INSTR) ? DONE : RECEIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_instruction = asm_q;
  assign o_word_count  = cnt_q;
  assign o_busy        = (state_q == CLEAR) || (state_q == RECEIVE) || (state_q == WRITE);
  assign o_done        = (state_q == DONE);
  assign o_error       = (state_q == ERROR);

endmodule
